// File: rtl/vga_box_gen.sv
// vga_box_gen: VGA timing generator that draws a solid box on a plain
// background and moves it by STEP pixels per debounced button press.
// Box position updates only on the first pixel of a frame, so a frame is
// never drawn with the box in two places.
// Optional build: define VGA_BORDER_EN to draw a white one-pixel frame on
// the outermost active columns and rows.
module vga_box_gen #(
    parameter int          H_ACTIVE   = 1920,
    parameter int          H_FP       = 88,
    parameter int          H_SYNC     = 44,
    parameter int          H_BP       = 148,
    parameter int          V_ACTIVE   = 1080,
    parameter int          V_FP       = 4,
    parameter int          V_SYNC     = 5,
    parameter int          V_BP       = 36,
    parameter bit          SYNC_POL   = 1'b1,
    parameter int          BOX_W      = 64,
    parameter int          BOX_H      = 64,
    parameter int          STEP       = 8,
    parameter int          DEB_CYCLES = 1485000,
    parameter logic [11:0] BOX_COLOR  = 12'hF00,
    parameter logic [11:0] BG_COLOR   = 12'h00F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    output logic       Hsync,
    output logic       Vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(DEB_CYCLES + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_EDGE = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] X_INIT = HW'((H_ACTIVE - BOX_W) / 2);
    localparam logic [HW:0]   X_MAX  = (HW + 1)'(H_ACTIVE - BOX_W);
    localparam logic [HW:0]   X_STEP = (HW + 1)'(STEP);
    localparam logic [HW:0]   X_SIZE = (HW + 1)'(BOX_W);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_EDGE = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] Y_INIT = VW'((V_ACTIVE - BOX_H) / 2);
    localparam logic [VW:0]   Y_MAX  = (VW + 1)'(V_ACTIVE - BOX_H);
    localparam logic [VW:0]   Y_STEP = (VW + 1)'(STEP);
    localparam logic [VW:0]   Y_SIZE = (VW + 1)'(BOX_H);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // Button bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right.
    logic [3:0]    btn_raw;
    logic [3:0]    sync_a;
    logic [3:0]    sync_b;
    logic [3:0]    deb_lvl;
    logic [3:0]    rise;
    logic [3:0]    pend;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          frame_tick;

    logic [HW-1:0] box_x;
    logic [VW-1:0] box_y;
    logic [HW-1:0] box_x_nxt;
    logic [VW-1:0] box_y_nxt;
    logic [HW:0]   x_up;
    logic [VW:0]   y_up;
    logic [HW:0]   x_end;
    logic [VW:0]   y_end;
    logic          in_act;
    logic          in_box;
    logic [11:0]   pix;
    logic [11:0]   rgb;

    assign btn_raw = {btnR, btnL, btnD, btnU};

    // Two-flop synchroniser for the asynchronous push-buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            logic [DW-1:0] cnt;
            logic          lvl;

            // Accept a new level after DEB_CYCLES consecutive samples that
            // disagree with the current one; an agreeing sample restarts.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt <= '0;
                    lvl <= 1'b0;
                end else if (sync_b[gi] == lvl) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    cnt <= '0;
                    lvl <= sync_b[gi];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign deb_lvl[gi] = lvl;
            // Rising edge of the accepted level, seen in the cycle it is taken.
            assign rise[gi]    = sync_b[gi] & ~lvl & (cnt == DEB_LAST);
        end
    endgenerate

    // Raster counters: h wraps at H_TOTAL, v advances on each h wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign frame_tick = (h_cnt == '0) && (v_cnt == '0);

    // Next box position: pending moves apply only on the frame tick, with
    // clamping at the screen edges and opposite directions cancelling.
    always_comb begin
        box_x_nxt = box_x;
        box_y_nxt = box_y;
        x_up      = {1'b0, box_x} + X_STEP;
        y_up      = {1'b0, box_y} + Y_STEP;
        if (frame_tick) begin
            if (pend[2] && !pend[3]) begin
                box_x_nxt = ({1'b0, box_x} >= X_STEP) ? box_x - X_STEP[HW-1:0] : '0;
            end else if (pend[3] && !pend[2]) begin
                box_x_nxt = (x_up > X_MAX) ? X_MAX[HW-1:0] : x_up[HW-1:0];
            end
            if (pend[0] && !pend[1]) begin
                box_y_nxt = ({1'b0, box_y} >= Y_STEP) ? box_y - Y_STEP[VW-1:0] : '0;
            end else if (pend[1] && !pend[0]) begin
                box_y_nxt = (y_up > Y_MAX) ? Y_MAX[VW-1:0] : y_up[VW-1:0];
            end
        end
    end

    // Pending flags collapse repeated presses; a press arriving on the
    // frame tick itself is kept for the following frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend  <= '0;
            box_x <= X_INIT;
            box_y <= Y_INIT;
        end else if (frame_tick) begin
            pend  <= rise;
            box_x <= box_x_nxt;
            box_y <= box_y_nxt;
        end else begin
            pend  <= pend | rise;
        end
    end

    // Pixel colour decode; uses the next position so the whole frame,
    // including its first pixel, shows the updated box.
    always_comb begin
        x_end  = {1'b0, box_x_nxt} + X_SIZE;
        y_end  = {1'b0, box_y_nxt} + Y_SIZE;
        in_act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_box = (h_cnt >= box_x_nxt) && ({1'b0, h_cnt} < x_end) &&
                 (v_cnt >= box_y_nxt) && ({1'b0, v_cnt} < y_end);
        if (!in_act) begin
            pix = 12'h000;
`ifdef VGA_BORDER_EN
        end else if ((h_cnt == '0) || (h_cnt == H_EDGE) ||
                     (v_cnt == '0) || (v_cnt == V_EDGE)) begin
            pix = 12'hFFF;
`endif
        end else if (in_box) begin
            pix = BOX_COLOR;
        end else begin
            pix = BG_COLOR;
        end
    end

    // Output registers: one clock after the counter values they decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Hsync       <= ~SYNC_POL;
            Vsync       <= ~SYNC_POL;
            rgb         <= 12'h000;
            frame_start <= 1'b0;
        end else begin
            Hsync       <= ((h_cnt >= HS_BEG) && (h_cnt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
            Vsync       <= ((v_cnt >= VS_BEG) && (v_cnt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
            rgb         <= pix;
            frame_start <= frame_tick;
        end
    end

    assign red   = rgb[11:8];
    assign green = rgb[7:4];
    assign blue  = rgb[3:0];

endmodule

// File: tb/tb_vga_box_gen.sv
// tb_vga_box_gen: drives button presses into vga_box_gen and compares every
// output cycle against a frame-level model of the raster and box position.
module tb_vga_box_gen;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int BOX_W    = 4;
  localparam int BOX_H    = 2;
  localparam int STEP     = 2;
  localparam int DEB      = 3;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int F_TOTAL  = H_TOTAL * V_TOTAL;

  // clock / reset / DUT signals
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btnU = 1'b0;
  logic       btnD = 1'b0;
  logic       btnL = 1'b0;
  logic       btnR = 1'b0;
  logic       Hsync;
  logic       Vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       frame_start;

  always #5 clk = ~clk;

  vga_box_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(1'b1), .BOX_W(BOX_W), .BOX_H(BOX_H), .STEP(STEP),
    .DEB_CYCLES(DEB), .BOX_COLOR(12'hF00), .BG_COLOR(12'h00F)
  ) dut (
    .clk(clk), .reset(reset),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .Hsync(Hsync), .Vsync(Vsync),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  // scoreboard state
  int          n_tests = 0;
  int          n_fail = 0;
  int          stream_prints = 0;
  logic [14:0] exp_q[$];
  int          press_cnt[4];
  int          seen_cnt[4];
  int          m_bx;
  int          m_by;
  int          idx;
  bit          fresh;
  int          hs_n;
  int          vs_n;
  int          fs_n;
  logic [11:0] fb [V_ACTIVE][H_ACTIVE];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_px(input string nm, input int x, input int y, input logic [11:0] e);
    check(nm, 32'(fb[y][x]), 32'(e));
  endtask

  // Expected colour of pixel (h,v) with the box at (bx,by).
  function automatic logic [11:0] model_pix(input int h, input int v, input int bx, input int by);
    if (h >= H_ACTIVE || v >= V_ACTIVE) return 12'h000;
`ifdef VGA_BORDER_EN
    if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) return 12'hFFF;
`endif
    if (h >= bx && h < bx + BOX_W && v >= by && v < by + BOX_H) return 12'hF00;
    return 12'h00F;
  endfunction

  // driver tasks
  task automatic set_btn(input int i, input logic val);
    case (i)
      0:       btnU = val;
      1:       btnD = val;
      2:       btnL = val;
      default: btnR = val;
    endcase
  endtask

  // Hold a button for 'hold' clocks then release for 8; it counts as a
  // press when held for at least DEB samples.
  task automatic press(input int i, input int hold);
    set_btn(i, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(i, 1'b0);
    repeat (8) @(negedge clk);
    if (hold >= DEB) press_cnt[i]++;
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < F_TOTAL + 20 && !seen; k++) begin
      @(negedge clk);
      if (frame_start) seen = 1'b1;
    end
    check("frame_start_timeout", 32'(seen), 32'(1));
  endtask

  task automatic do_frame(input logic [3:0] pmask, input logic [3:0] dmask, input logic [3:0] gmask);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pmask[i]) begin
        press(i, 8);
        if (dmask[i]) press(i, 8);
      end else if (gmask[i]) begin
        press(i, $urandom_range(1, 2));
      end
    end
    wait_frame();
  endtask

  initial begin
    int ys[4];
    logic [3:0] pm;
    logic [3:0] dm;
    logic [3:0] gm;
    ys = '{1, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      press_cnt[i] = 0;
      seen_cnt[i] = 0;
    end
    fresh = 1'b1;
    idx = 0;

    // compare process: every negedge, reset values or the modelled stream
    fork
      forever begin
        int h;
        int v;
        bit u_p, d_p, l_p, r_p;
        logic [14:0] e;
        logic [14:0] got;
        @(negedge clk);
        if (!reset) begin
          check("rst_hsync", 32'(Hsync), 32'(0));
          check("rst_vsync", 32'(Vsync), 32'(0));
          check("rst_rgb", 32'({red, green, blue}), 32'(0));
          check("rst_frame_start", 32'(frame_start), 32'(0));
          fresh = 1'b1;
          m_bx = (H_ACTIVE - BOX_W) / 2;
          m_by = (V_ACTIVE - BOX_H) / 2;
          for (int i = 0; i < 4; i++) seen_cnt[i] = press_cnt[i];
        end else begin
          idx = fresh ? 0 : (idx + 1) % F_TOTAL;
          fresh = 1'b0;
          h = idx % H_TOTAL;
          v = idx / H_TOTAL;
          if (idx == 0) begin
            u_p = press_cnt[0] != seen_cnt[0];
            d_p = press_cnt[1] != seen_cnt[1];
            l_p = press_cnt[2] != seen_cnt[2];
            r_p = press_cnt[3] != seen_cnt[3];
            if (u_p && !d_p) m_by = (m_by - STEP < 0) ? 0 : m_by - STEP;
            if (d_p && !u_p) m_by = (m_by + STEP > V_ACTIVE - BOX_H) ? V_ACTIVE - BOX_H : m_by + STEP;
            if (l_p && !r_p) m_bx = (m_bx - STEP < 0) ? 0 : m_bx - STEP;
            if (r_p && !l_p) m_bx = (m_bx + STEP > H_ACTIVE - BOX_W) ? H_ACTIVE - BOX_W : m_bx + STEP;
            for (int i = 0; i < 4; i++) seen_cnt[i] = press_cnt[i];
            hs_n = 0;
            vs_n = 0;
            fs_n = 0;
          end
          exp_q.push_back({(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC),
                           (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC),
                           (idx == 0),
                           model_pix(h, v, m_bx, m_by)});
          e = exp_q.pop_front();
          got = {Hsync, Vsync, frame_start, red, green, blue};
          n_tests++;
          if (got !== e) begin
            n_fail++;
            if (stream_prints < 20) begin
              stream_prints++;
              $display("FAIL stream h=%0d v=%0d: got hs/vs/fs/rgb %h, expected %h", h, v, got, e);
            end
          end
          if (h < H_ACTIVE && v < V_ACTIVE) fb[v][h] = {red, green, blue};
          hs_n += int'(Hsync);
          vs_n += int'(Vsync);
          fs_n += int'(frame_start);
          if (idx == F_TOTAL - 1) begin
            check("hsync_high_per_frame", 32'(hs_n), 32'(22));
            check("vsync_high_per_frame", 32'(vs_n), 32'(22));
            check("frame_start_per_frame", 32'(fs_n), 32'(1));
          end
        end
      end
    join_none

    // reset release
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    wait_frame();
    repeat (17) @(negedge clk);
    check("blank_rgb_h17", 32'({red, green, blue}), 32'h000);
    check("hsync_h17", 32'(Hsync), 32'(0));
    @(negedge clk);
    check("hsync_h18", 32'(Hsync), 32'(1));
    wait_frame();
    check("model_box_x_reset", 32'(m_bx), 32'(6));
    check("model_box_y_reset", 32'(m_by), 32'(3));
    check_px("px_6_3_box", 6, 3, 12'hF00);
    check_px("px_5_3_bg", 5, 3, 12'h00F);
    check_px("px_9_4_box", 9, 4, 12'hF00);
    check_px("px_10_3_bg", 10, 3, 12'h00F);
    check_px("px_6_5_bg", 6, 5, 12'h00F);

    // btnD held 10 clocks, then kept down through 3 more frames
    repeat (40) @(negedge clk);
    btnD = 1'b1;
    repeat (10) @(negedge clk);
    press_cnt[1]++;
    wait_frame();
    wait_frame();
    check("model_box_y_down", 32'(m_by), 32'(5));
    check_px("down_px_6_5_box", 6, 5, 12'hF00);
    check_px("down_px_6_4_bg", 6, 4, 12'h00F);
    wait_frame();
    wait_frame();
    btnD = 1'b0;
    wait_frame();
    check("model_box_y_held", 32'(m_by), 32'(5));
    check_px("held_px_6_6_box", 6, 6, 12'hF00);
    check_px("held_px_6_4_bg", 6, 4, 12'h00F);
`ifdef VGA_BORDER_EN
    check_px("border_0_3", 0, 3, 12'hFFF);
    check_px("border_15_3", 15, 3, 12'hFFF);
    check_px("border_3_0", 3, 0, 12'hFFF);
    check_px("border_3_7", 3, 7, 12'hFFF);
`else
    check_px("noborder_0_3", 0, 3, 12'h00F);
    check_px("noborder_15_3", 15, 3, 12'h00F);
    check_px("noborder_3_7", 3, 7, 12'h00F);
`endif

    // mid-frame reset, then counting restarts at (0,0)
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("frame_start_after_reset", 32'(frame_start), 32'(1));

    // btnU four times from y=3: 1, 0, 0, 0
    for (int k = 0; k < 4; k++) begin
      repeat (40) @(negedge clk);
      press(0, 8);
      wait_frame();
      wait_frame();
      check("model_box_y_up", 32'(m_by), 32'(ys[k]));
      check_px("up_px_box", 6, ys[k] + 1, 12'hF00);
      check_px("up_px_bg", 6, ys[k] + BOX_H, 12'h00F);
    end

    // left and right in one frame cancel; a short glitch is ignored
    repeat (40) @(negedge clk);
    press(2, 8);
    press(3, 8);
    wait_frame();
    wait_frame();
    check("model_box_x_lr", 32'(m_bx), 32'(6));
    check_px("lr_px_6_1_box", 6, 1, 12'hF00);
    check_px("lr_px_5_1_bg", 5, 1, 12'h00F);
    repeat (40) @(negedge clk);
    press(3, 2);
    wait_frame();
    wait_frame();
    check("model_box_x_glitch", 32'(m_bx), 32'(6));
    check_px("glitch_px_6_1_box", 6, 1, 12'hF00);
    check_px("glitch_px_5_1_bg", 5, 1, 12'h00F);

    // right four times clamps at H_ACTIVE-BOX_W = 12
    for (int k = 0; k < 4; k++) begin
      repeat (40) @(negedge clk);
      press(3, 8);
      wait_frame();
    end
    wait_frame();
    check("model_box_x_clamp", 32'(m_bx), 32'(12));
    check_px("clamp_px_14_1_box", 14, 1, 12'hF00);
    check_px("clamp_px_11_1_bg", 11, 1, 12'h00F);

    // randomized frames
    for (int f = 0; f < 20; f++) begin
      pm = 4'($urandom_range(0, 15));
      dm = 4'($urandom_range(0, 15)) & pm;
      gm = 4'($urandom_range(0, 15)) & ~pm;
      do_frame(pm, dm, gm);
    end
    wait_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
